riscv_mem_responder: RTL and testbench
======================================

RISCV_MEM_RESPONDER -- requirements
Module: riscv_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning byte-address bits of the local store (4 KiB, word-organised).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning wait states inserted before each response (legal 0..15).
REQ-003 SHALL have port clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_ren_i  input  1  read request; the requester holds it until mem_ready_o.
REQ-006 SHALL have port mem_wen_i  input  1  write request; the requester holds it until mem_ready_o.
REQ-007 SHALL have port mem_addr_i  input  32  byte address.
REQ-008 SHALL have port mem_wdata_i  input  32  store data, right-justified.
REQ-009 SHALL have port mem_size_i  input  2  access size: 00=byte, 01=half, 10=word, 11=illegal.
REQ-010 SHALL have port mem_unsigned_i  input  1  zero-extend load data when 1.
REQ-011 SHALL have port mem_rdata_o  output  32  load data, right-justified and extended.
REQ-012 SHALL have port mem_ready_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have port mem_err_o  output  1  access fault, qualified by mem_ready_o.
REQ-014 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 IDLE SHALL sample a request when mem_ren_i|mem_wen_i; on that edge it SHALL latch addr, wdata, size, unsigned and op, then go to WAIT, or directly to RESP if WAIT_CYCLES==0.
REQ-017 WAIT SHALL load a down-counter with WAIT_CYCLES-1 on entry; it SHALL move to RESP on the edge where the counter is 0.
REQ-018 RESP SHALL last exactly one cycle with mem_ready_o=1, then return to IDLE unconditionally.
REQ-019 Latency: mem_ready_o SHALL be high in cycle WAIT_CYCLES+1 after the sampling edge.
REQ-020 A request still held in the cycle after RESP SHALL start a new access, so the minimum gap between ready pulses is WAIT_CYCLES+2 cycles.
REQ-021 Requests seen outside IDLE SHALL be ignored, and latched fields SHALL NOT change mid-access.
REQ-022 Write: on the edge entering RESP, the latched data SHALL be written to lane addr[1:0] using byte enables.
  - byte: data[7:0] to one lane
  - half: data[15:0] to lanes {a1,0}
  - word: all four lanes
  - all other lanes unchanged
REQ-023 Read: on the edge entering RESP, mem_rdata_o SHALL be registered from the selected lane(s), sign-extended unless mem_unsigned_i is 1.
REQ-024 For a word read, mem_unsigned_i SHALL be ignored.
REQ-025 mem_rdata_o SHALL hold its value until the next read completes; after a write it SHALL be unchanged.
REQ-026 Fault conditions SHALL be any of:
  - mem_ren_i and mem_wen_i both high
  - mem_size_i==11
  - mem_addr_i >= 2**ADDR_WIDTH
  - misalignment per REQ-033
REQ-027 On a fault: mem_err_o=1 together with mem_ready_o, no memory write, mem_rdata_o=0.
REQ-028 On a fault, latency SHALL be identical to a normal access.
REQ-029 mem_err_o SHALL be 0 whenever mem_ready_o is 0.

Reset
REQ-030 While reset_n is low: FSM=IDLE, counter=0, and mem_rdata_o, mem_ready_o, mem_err_o and busy_o all 0; latched fields SHALL clear to 0.
REQ-031 Reset asserted mid-access SHALL abort the access; a write not yet in RESP SHALL NOT commit.
REQ-032 Storage contents SHALL NOT be reset.

Configuration
REQ-033 With macro RISCV_MEM_ALIGN_CHECK_EN defined, the following SHALL fault:
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
REQ-034 Without RISCV_MEM_ALIGN_CHECK_EN, misalignment SHALL NOT fault.
  - half access: addr[0] forced to 0
  - word access: addr[1:0] forced to 0
  - all other faults still apply

Structure
REQ-035 Package riscv_mem_pkg SHALL hold the size encodings (SIZE_BYTE/HALF/WORD), the state_t enum and the WAIT_CYCLES range limit.
REQ-036 Sub-module riscv_mem_lane (combinational) SHALL hold write-lane steering, byte-enable generation and read extraction/extension; the FSM and storage remain in the top module.

Verification (WAIT_CYCLES=1 unless stated)
REQ-037 Word store then load: wen, addr 0x10, wdata 0xDEADBEEF, size 10, then ren at 0x10 -> ready at cycle 2 each time, rdata 0xDEADBEEF, err 0.
REQ-038 Byte load, sign and zero extension: store 0x000080FF word at 0x20; load byte at 0x21, unsigned=0 -> 0xFFFFFF80; unsigned=1 -> 0x00000080; load half at 0x20, unsigned=0 -> 0xFFFF80FF.
REQ-039 Byte store merge: word 0x11223344 at 0x30; store byte 0xAA at 0x32 -> word load at 0x30 returns 0x11AA3344.
REQ-040 Faults: size 11; addr 0x1000; ren+wen together -> each gives ready with err=1 and rdata=0; following word load at 0x30 confirms memory unchanged.
REQ-041 Misalign at word 0x31 -> err=1 with RISCV_MEM_ALIGN_CHECK_EN; without it, returns word at 0x30 with err=0.
REQ-042 Reset and zero-wait: reset_n low in the WAIT cycle of a store to 0x40 -> outputs 0 and no commit at 0x40; rebuild with WAIT_CYCLES=0 and hold ren -> ready pulses every 2 cycles.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
//   Shared definitions for the riscv_mem_responder block:
//   - access size encodings carried on mem_size_i
//   - FSM state type
//   - legal upper bound for the WAIT_CYCLES parameter
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam int WAIT_CYCLES_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// riscv_mem_responder_if
//   Request/response bundle between a load/store unit (master) and the
//   local memory responder (slave).
//   master drives : mem_ren_i, mem_wen_i, mem_addr_i, mem_wdata_i,
//                   mem_size_i, mem_unsigned_i
//   slave drives  : mem_rdata_o, mem_ready_o, mem_err_o, busy_o
interface riscv_mem_responder_if;
  logic        mem_ren_i;
  logic        mem_wen_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        mem_err_o;
  logic        busy_o;

  modport master (
    output mem_ren_i, mem_wen_i, mem_addr_i, mem_wdata_i, mem_size_i, mem_unsigned_i,
    input  mem_rdata_o, mem_ready_o, mem_err_o, busy_o
  );

  modport slave (
    input  mem_ren_i, mem_wen_i, mem_addr_i, mem_wdata_i, mem_size_i, mem_unsigned_i,
    output mem_rdata_o, mem_ready_o, mem_err_o, busy_o
  );
endinterface

// File: rtl/riscv_mem_lane.sv
// riscv_mem_lane
//   Combinational byte-lane logic for the memory responder.
//   addr_lo_i  : address bits [1:0] of the access
//   size_i     : access size (byte/half/word)
//   unsigned_i : zero-extend sub-word loads when 1
//   wdata_i    : right-justified store data
//   rword_i    : full word read from storage
//   be_o       : per-byte write enables
//   wlane_o    : store data replicated onto the byte lanes
//   rdata_o    : load data, right-justified and extended
//   Sub-word offsets are always forced to natural alignment here; when the
//   alignment check is enabled a misaligned access faults before any of
//   these values are used, so the forcing is harmless in that build.
module riscv_mem_lane
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  off;
  logic [15:0] shifted;

  assign off = (size_i == SIZE_BYTE) ? addr_lo_i :
               (size_i == SIZE_HALF) ? {addr_lo_i[1], 1'b0} : 2'b00;

  // Bring the addressed byte/half down to bit 0.
  assign shifted = 16'(rword_i >> {off, 3'b000});

  always_comb begin
    be_o    = 4'b0000;
    wlane_o = wdata_i;
    rdata_o = 32'h0;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << off;
        wlane_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        be_o    = 4'b0011 << off;
        wlane_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'h0, shifted}
                             : {{16{shifted[15]}}, shifted};
      end
      SIZE_WORD: begin
        be_o    = 4'b1111;
        wlane_o = wdata_i;
        rdata_o = rword_i;
      end
      default: begin
        be_o    = 4'b0000;
        rdata_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder
//   Word-organised local store answering one load/store at a time with a
//   fixed number of wait states.
//   Parameters : ADDR_WIDTH  byte-address bits of the store (default 12)
//                WAIT_CYCLES wait states before each response (0..15)
//   Ports      : clock   rising-edge clock
//                reset_n asynchronous active-low reset
//                bus     riscv_mem_responder_if.slave request/response bundle
//   Build option: define RISCV_MEM_ALIGN_CHECK_EN to fault misaligned
//   half/word accesses; otherwise they are silently aligned down.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  riscv_mem_responder_if.slave   bus
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait
    $error("WAIT_CYCLES out of range");
  end

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  // In IDLE with zero wait states the access completes on the sampling
  // edge itself, so the live request fields are used; otherwise the
  // latched copies are.
  logic        req;
  logic        in_idle;
  logic        go_resp;
  logic        fault;
  logic        mem_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [1:0]  acc_size;
  logic        acc_uns, acc_ren, acc_wen;
  logic [IDX_W-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlane, rword, lane_rdata;

  assign req     = bus.mem_ren_i | bus.mem_wen_i;
  assign in_idle = (state_q == IDLE);
  assign go_resp = (in_idle && req && (WAIT_CYCLES == 0)) ||
                   ((state_q == WAIT) && (cnt_q == 4'd0));

  assign acc_addr  = in_idle ? bus.mem_addr_i     : addr_q;
  assign acc_wdata = in_idle ? bus.mem_wdata_i    : wdata_q;
  assign acc_size  = in_idle ? bus.mem_size_i     : size_q;
  assign acc_uns   = in_idle ? bus.mem_unsigned_i : uns_q;
  assign acc_ren   = in_idle ? bus.mem_ren_i      : ren_q;
  assign acc_wen   = in_idle ? bus.mem_wen_i      : wen_q;

  always_comb begin
    fault = (acc_ren && acc_wen) ||
            (acc_size == SIZE_ILL) ||
            ((acc_addr >> ADDR_WIDTH) != 32'h0);
`ifdef RISCV_MEM_ALIGN_CHECK_EN
    fault = fault ||
            ((acc_size == SIZE_HALF) && acc_addr[0]) ||
            ((acc_size == SIZE_WORD) && (acc_addr[1:0] != 2'b00));
`else
    fault = fault;
`endif
  end

  assign idx    = acc_addr[ADDR_WIDTH-1:2];
  assign mem_we = go_resp && acc_wen && !fault;

  riscv_mem_lane u_lane (
    .addr_lo_i  (acc_addr[1:0]),
    .size_i     (acc_size),
    .unsigned_i (acc_uns),
    .wdata_i    (acc_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wlane_o    (wlane),
    .rdata_o    (lane_rdata)
  );

  // One byte-wide array per lane so each byte enable maps onto its own
  // storage; contents are deliberately not reset.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH];

    always_ff @(posedge clock) begin
      if (mem_we && be[gi]) begin
        mem_lane[idx] <= wlane[8*gi +: 8];
      end
    end

    assign rword[8*gi +: 8] = mem_lane[idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus.mem_addr_i;
          wdata_d = bus.mem_wdata_i;
          size_d  = bus.mem_size_i;
          uns_d   = bus.mem_unsigned_i;
          ren_d   = bus.mem_ren_i;
          wen_d   = bus.mem_wen_i;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_resp) begin
      ready_d = 1'b1;
      err_d   = fault;
      if (fault) begin
        rdata_d = 32'h0;
      end else if (acc_ren) begin
        rdata_d = lane_rdata;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.mem_rdata_o = rdata_q;
  assign bus.mem_ready_o = ready_q;
  assign bus.mem_err_o   = err_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// tb_riscv_mem_responder
//   Table-driven check of the memory responder (WAIT_CYCLES=1 instance)
//   plus hand-written sequences for reset mid-access and back-to-back
//   requests on a WAIT_CYCLES=0 instance. Expected responses are queued
//   when a request is driven and compared when mem_ready_o fires.
module tb_riscv_mem_responder;
  import riscv_mem_pkg::*;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  riscv_mem_responder_if bus0 ();
  riscv_mem_responder_if bus1 ();

  riscv_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  riscv_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic ren, input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.size = size; v.uns = uns; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic idle0();
    bus0.mem_ren_i = 1'b0; bus0.mem_wen_i = 1'b0; bus0.mem_addr_i = 32'h0;
    bus0.mem_wdata_i = 32'h0; bus0.mem_size_i = 2'b00; bus0.mem_unsigned_i = 1'b0;
  endtask

  task automatic idle1();
    bus1.mem_ren_i = 1'b0; bus1.mem_wen_i = 1'b0; bus1.mem_addr_i = 32'h0;
    bus1.mem_wdata_i = 32'h0; bus1.mem_size_i = 2'b00; bus1.mem_unsigned_i = 1'b0;
  endtask

  // Drive one request on dut0, hold it until ready, then compare.
  task automatic run0(input int n, input vec_t v);
    int   cycles;
    logic got;
    exp_t e;
    @(negedge clock);
    bus0.mem_ren_i = v.ren; bus0.mem_wen_i = v.wen; bus0.mem_addr_i = v.addr;
    bus0.mem_wdata_i = v.wdata; bus0.mem_size_i = v.size; bus0.mem_unsigned_i = v.uns;
    sb0.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 20) begin
      @(negedge clock);
      cycles++;
      if (bus0.mem_ready_o) begin
        got = 1'b1;
      end else begin
        check($sformatf("v%0d busy_while_waiting", n), {31'h0, bus0.busy_o}, 32'h1);
        check($sformatf("v%0d err_without_ready", n), {31'h0, bus0.mem_err_o}, 32'h0);
      end
    end
    check($sformatf("v%0d latency", n), cycles, 32'd2);
    if (got) begin
      e = sb0.pop_front();
      check($sformatf("v%0d rdata", n), bus0.mem_rdata_o, e.rdata);
      check($sformatf("v%0d err", n), {31'h0, bus0.mem_err_o}, {31'h0, e.err});
    end
    $display("txn %0d: ren=%0b wen=%0b addr=0x%08h size=%0d uns=%0b -> rdata=0x%08h err=%0b cycles=%0d",
             n, v.ren, v.wen, v.addr, v.size, v.uns, bus0.mem_rdata_o, bus0.mem_err_o, cycles);
    idle0();
  endtask

  initial begin
    exp_t e;
    idle0();
    idle1();

    // Expected rdata on writes is the value of the previous completed read.
    vecs[0]  = mk(0, 1, 32'h10,   32'hDEADBEEF, SIZE_WORD, 0, 32'h00000000, 0);
    vecs[1]  = mk(1, 0, 32'h10,   32'h0,        SIZE_WORD, 1, 32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 1, 32'h20,   32'h000080FF, SIZE_WORD, 0, 32'hDEADBEEF, 0);
    vecs[3]  = mk(1, 0, 32'h21,   32'h0,        SIZE_BYTE, 0, 32'hFFFFFF80, 0);
    vecs[4]  = mk(1, 0, 32'h21,   32'h0,        SIZE_BYTE, 1, 32'h00000080, 0);
    vecs[5]  = mk(1, 0, 32'h20,   32'h0,        SIZE_HALF, 0, 32'hFFFF80FF, 0);
    vecs[6]  = mk(0, 1, 32'h30,   32'h11223344, SIZE_WORD, 0, 32'hFFFF80FF, 0);
    vecs[7]  = mk(0, 1, 32'h32,   32'h000000AA, SIZE_BYTE, 0, 32'hFFFF80FF, 0);
    vecs[8]  = mk(1, 0, 32'h30,   32'h0,        SIZE_WORD, 0, 32'h11AA3344, 0);
    vecs[9]  = mk(0, 1, 32'h30,   32'hFFFFFFFF, SIZE_ILL,  0, 32'h00000000, 1);
    vecs[10] = mk(1, 0, 32'h1000, 32'h0,        SIZE_WORD, 0, 32'h00000000, 1);
    vecs[11] = mk(1, 1, 32'h30,   32'h55555555, SIZE_WORD, 0, 32'h00000000, 1);
    vecs[12] = mk(1, 0, 32'h30,   32'h0,        SIZE_WORD, 0, 32'h11AA3344, 0);
    vecs[13] = mk(0, 1, 32'h34,   32'h00000000, SIZE_WORD, 0, 32'h11AA3344, 0);
    vecs[14] = mk(0, 1, 32'h36,   32'h1234BEEF, SIZE_HALF, 0, 32'h11AA3344, 0);
    vecs[15] = mk(1, 0, 32'h34,   32'h0,        SIZE_WORD, 1, 32'hBEEF0000, 0);
    vecs[16] = mk(1, 0, 32'h36,   32'h0,        SIZE_HALF, 0, 32'hFFFFBEEF, 0);
    vecs[17] = mk(1, 0, 32'h36,   32'h0,        SIZE_HALF, 1, 32'h0000BEEF, 0);
    vecs[18] = mk(1, 0, 32'h30,   32'h0,        SIZE_BYTE, 0, 32'h00000044, 0);
    vecs[19] = mk(1, 0, 32'h37,   32'h0,        SIZE_BYTE, 0, 32'hFFFFFFBE, 0);
    vecs[20] = mk(0, 1, 32'h40,   32'h01020304, SIZE_WORD, 0, 32'hFFFFFFBE, 0);
`ifdef RISCV_MEM_ALIGN_CHECK_EN
    vecs[21] = mk(1, 0, 32'h31,   32'h0,        SIZE_WORD, 0, 32'h00000000, 1);
`else
    vecs[21] = mk(1, 0, 32'h31,   32'h0,        SIZE_WORD, 0, 32'h11AA3344, 0);
`endif

    // Reset state
    repeat (3) @(negedge clock);
    check("reset rdata", bus0.mem_rdata_o, 32'h0);
    check("reset ready", {31'h0, bus0.mem_ready_o}, 32'h0);
    check("reset err",   {31'h0, bus0.mem_err_o}, 32'h0);
    check("reset busy",  {31'h0, bus0.busy_o}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      run0(i, vecs[i]);
    end

    // Reset during the WAIT cycle of a store must abort it without commit.
    @(negedge clock);
    bus0.mem_wen_i = 1'b1; bus0.mem_addr_i = 32'h40;
    bus0.mem_wdata_i = 32'hCAFEF00D; bus0.mem_size_i = SIZE_WORD;
    @(negedge clock);
    check("abort busy_before_reset", {31'h0, bus0.busy_o}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("abort rdata", bus0.mem_rdata_o, 32'h0);
    check("abort ready", {31'h0, bus0.mem_ready_o}, 32'h0);
    check("abort err",   {31'h0, bus0.mem_err_o}, 32'h0);
    check("abort busy",  {31'h0, bus0.busy_o}, 32'h0);
    $display("txn abort: store 0x40 interrupted by reset, rdata=0x%08h busy=%0b",
             bus0.mem_rdata_o, bus0.busy_o);
    @(negedge clock);
    idle0();
    @(negedge clock);
    check("abort still_idle", {31'h0, bus0.busy_o}, 32'h0);
    reset_n = 1'b1;
    run0(100, mk(1, 0, 32'h40, 32'h0, SIZE_WORD, 0, 32'h01020304, 0));

    // Zero-wait instance: single write, then a held read.
    @(negedge clock);
    bus1.mem_wen_i = 1'b1; bus1.mem_addr_i = 32'h50;
    bus1.mem_wdata_i = 32'h0BADF00D; bus1.mem_size_i = SIZE_WORD;
    sb1.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clock);
    check("zw write ready", {31'h0, bus1.mem_ready_o}, 32'h1);
    if (bus1.mem_ready_o) begin
      e = sb1.pop_front();
      check("zw write err", {31'h0, bus1.mem_err_o}, {31'h0, e.err});
      check("zw write rdata", bus1.mem_rdata_o, e.rdata);
    end
    $display("txn zw write: addr=0x00000050 ready=%0b err=%0b", bus1.mem_ready_o, bus1.mem_err_o);
    idle1();
    @(negedge clock);
    bus1.mem_ren_i = 1'b1; bus1.mem_addr_i = 32'h50; bus1.mem_size_i = SIZE_WORD;
    for (int k = 0; k < 4; k++) sb1.push_back('{rdata: 32'h0BADF00D, err: 1'b0});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      check($sformatf("zw held ready k%0d", k), {31'h0, bus1.mem_ready_o}, {31'h0, (k % 2) == 1});
      if (bus1.mem_ready_o && sb1.size() > 0) begin
        e = sb1.pop_front();
        check($sformatf("zw held rdata k%0d", k), bus1.mem_rdata_o, e.rdata);
        check($sformatf("zw held err k%0d", k), {31'h0, bus1.mem_err_o}, {31'h0, e.err});
        $display("txn zw read k%0d: rdata=0x%08h err=%0b", k, bus1.mem_rdata_o, bus1.mem_err_o);
      end
    end
    idle1();
    check("zw scoreboard drained", sb1.size(), 32'd0);
    check("scoreboard0 drained", sb0.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
